// File: rtl/sample_deser.sv
`timescale 1ns/1ps
// Serial-to-parallel deserializer: LSB-first bits qualified by SV, frames opened by SYNC,
// optional odd-parity bit, one-cycle QV strobe and a wrapping good-frame counter.
module sample_deser #(
  parameter int unsigned W   = 8,
  parameter int unsigned PAR = 1,
  parameter int unsigned CW  = 8
) (
  input  logic          CK,
  input  logic          RB,
  input  logic          SI,
  input  logic          SV,
  input  logic          SYNC,
  output logic [W-1:0]  Q,
  output logic          QV,
  output logic          PERR,
  output logic [CW-1:0] FCNT
);

  localparam int unsigned CNTW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PARB = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [W-1:0]    sh_q;
  logic            par_q;   // running XOR of the data bits received so far
  logic [W-1:0]    q_q;
  logic            qv_q;
  logic            perr_q;
  logic [CW-1:0]   fcnt_q;

  logic [W-1:0]    sh_ins_c;
  logic            par_ins_c;
  logic            last_c;
  logic            perr_c;

  // Shift register with the current bit placed at position cnt, and frame-boundary decode.
  always_comb begin
    sh_ins_c  = sh_q | (W'(SI) << cnt_q);
    par_ins_c = par_q ^ SI;
    last_c    = (cnt_q == CNTW'(W - 1));
    // Odd parity: XOR over data and parity bit must be 1.
    perr_c    = ~(par_q ^ SI);
  end

  // Single-register FSM; outputs are updated on the edge accepting the last bit so QV
  // is visible throughout the DONE cycle.
  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      perr_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      qv_q <= 1'b0;
      if (state_q == DONE) begin
        state_q <= IDLE;
      end
      if (SV) begin
        if (SYNC) begin
          // SYNC always opens a new frame, aborting any frame in progress.
          state_q <= DATA;
          cnt_q   <= CNTW'(1);
          sh_q    <= W'(SI);
          par_q   <= SI;
        end else begin
          unique case (state_q)
            DATA: begin
              sh_q  <= sh_ins_c;
              par_q <= par_ins_c;
              cnt_q <= cnt_q + CNTW'(1);
              if (last_c) begin
                if (PAR != 0) begin
                  state_q <= PARB;
                end else begin
                  state_q <= DONE;
                  q_q     <= sh_ins_c;
                  qv_q    <= 1'b1;
                  perr_q  <= 1'b0;
                  fcnt_q  <= fcnt_q + CW'(1);
                end
              end
            end
            PARB: begin
              state_q <= DONE;
              q_q     <= sh_q;
              qv_q    <= 1'b1;
              perr_q  <= perr_c;
              if (!perr_c) begin
                fcnt_q <= fcnt_q + CW'(1);
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign Q    = q_q;
  assign QV   = qv_q;
  assign PERR = perr_q;
  assign FCNT = fcnt_q;

endmodule

// File: doc/sample_deser.md
Name: sample_deser

Overview:
Serial-to-parallel deserializer used as the sample sequential design for the STA flow. It is synthesised onto the course cell set: inverters, buffers, 2-input NAND/NOR and the async-reset D flop. Only reset-type flops are available, so every register has an asynchronous active-low clear and no set. It accepts one serial bit per qualified clock, LSB first, with optional odd-parity checking. It presents the assembled word with a one-cycle valid strobe and keeps a count of good frames.

Parameters:
W, 8, data word width in bits (2..16)
PAR, 1, 1 = one odd-parity bit follows the data bits; 0 = no parity bit
CW, 8, width of the good-frame counter

Ports:
CK  input  1  clock; all flops rise-edge triggered
RB  input  1  reset, asynchronous, active-low; clears all state
SI  input  1  serial data bit
SV  input  1  SI qualifier; a bit is accepted only on a CK rise with SV=1
SYNC  input  1  start-of-frame marker; meaningful only when SV=1
Q  output  W  last assembled data word
QV  output  1  one-cycle strobe: Q/PERR updated this cycle
PERR  output  1  parity error flag for the word in Q; valid with QV
FCNT  output  CW  count of frames received without parity error, wraps

Behaviour:
- Reset (RB=0, asynchronous, any time including mid-frame): state=IDLE, bit counter=0, shift reg=0, Q=0, QV=0, PERR=0, FCNT=0. The partial frame is discarded. The first accepted bit after RB rises must carry SYNC.
- An "accepted bit" is a CK rise with SV=1. SV=0 is a stall: state, counter and shift register all hold. The stall length is unbounded.
- States:
  - IDLE: accepted bit with SYNC=1 -> capture SI as data bit 0, cnt=1, go to DATA. Accepted bit with SYNC=0 is ignored.
  - DATA: each accepted bit shifts SI into position cnt (LSB first) and increments cnt. When bit W-1 is accepted, go to PARB if PAR=1, else go to DONE.
  - PARB: the accepted bit is the parity bit. Odd parity: popcount(data)+parity must be odd. Go to DONE.
  - DONE: single cycle, no bit consumed here. Q <= data; QV=1; PERR = parity mismatch (always 0 if PAR=0). FCNT increments only if PERR=0. Return to IDLE.
- SYNC=1 on an accepted bit in DATA or PARB aborts the frame. That bit becomes data bit 0 of a new frame (cnt=1, DATA). No QV is generated for the aborted frame, and Q/FCNT hold.
- An accepted bit arriving in the DONE cycle is accepted as if in IDLE, so back-to-back frames have zero gap. SYNC=1 starts a new frame; SYNC=0 is dropped.
- Latency: QV is high in the cycle after the CK rise that accepts the last bit (parity bit if PAR=1, else data bit W-1).
- QV is exactly one cycle wide. Q and PERR hold until the next DONE.
- PERR=1 still updates Q with the received (suspect) data.
- FCNT wraps from 2^CW-1 to 0 with no flag.
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs.
- Counter width is ceil(log2(W+1)).

Test Plan:
- Reset then frame W=8, PAR=1: SYNC with bit0, bits of 0xA5 LSB first, parity=1 -> QV pulses one cycle after the parity bit, Q=0xA5, PERR=0, FCNT=1.
- Same data with parity=0 -> Q=0xA5, PERR=1, QV pulse, FCNT stays 1.
- 0x3C frame with SV=0 for 5 cycles inserted after bit 3 -> Q=0x3C, PERR=0, QV delayed by exactly 5 cycles versus no stall.
- Start 0xFF frame, assert SYNC again at bit 5 with new frame 0x12 (parity 1) -> no QV for the first frame, then Q=0x12, FCNT+1. Separately, drop RB low for half a cycle at bit 4 -> all outputs 0 immediately; the following full frame decodes correctly.
- Preload 255 good frames, send one more good frame -> FCNT wraps to 0, QV pulses. Back-to-back frames with SYNC in the DONE cycle -> two QV pulses 9 cycles apart (W=8, PAR=1).
- PAR=0 build: frame 0x81 -> QV one cycle after bit 7, PERR=0. Accepted bits with SYNC=0 in IDLE -> ignored, no QV.
